// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundles the instruction port, data port and memory-side bus
//               signals of the I/D memory port arbiter. The slave modport is
//               the arbiter's view; the master modport is the core and memory
//               side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Instruction-fetch port
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    // Load/store data port
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    // Unified memory side
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_rdata, i_ready, d_rdata, d_ready,
               mem_en, mem_we, mem_addr, mem_wdata, err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_rdata, i_ready, d_rdata, d_ready,
               mem_en, mem_we, mem_addr, mem_wdata, err
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between the instruction-fetch
//               port and the load/store port. Round-robin on simultaneous
//               requests, one transaction at a time, fixed timeout when the
//               memory never acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_port_arbiter_if.slave bus
);

    localparam int              C_CW       = $clog2(TIMEOUT);
    localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_last_gnt_d;   // 1: data port won the most recent grant
    logic [C_CW-1:0] r_cnt;          // BUSY cycles elapsed without mem_ack
    logic            w_grant_i;

    // On a tie the instruction port wins unless it was the last one granted
    assign w_grant_i = bus.i_req && (!bus.d_req || r_last_gnt_d);

    // Arbitration FSM; every output is a register so the memory and the core
    // see glitch-free, edge-aligned strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_last_gnt_d  <= 1'b1;
            r_cnt         <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
            bus.i_ready   <= 1'b0;
            bus.d_ready   <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            // Completion strobes are single-cycle pulses
            bus.i_ready <= 1'b0;
            bus.d_ready <= 1'b0;
            bus.err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_grant_i) begin
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.i_addr;
                        bus.mem_wdata <= '0;
                        r_last_gnt_d  <= 1'b0;
                        r_state       <= S_BUSY_I;
                    end else if (bus.d_req) begin
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= bus.d_we;
                        bus.mem_addr  <= bus.d_addr;
                        bus.mem_wdata <= bus.d_wdata;
                        r_last_gnt_d  <= 1'b1;
                        r_state       <= S_BUSY_D;
                    end
                end
                S_BUSY_I, S_BUSY_D: begin
                    // An acknowledge in the final allowed cycle still counts
                    if (bus.mem_ack) begin
                        bus.mem_en <= 1'b0;
                        bus.mem_we <= 1'b0;
                        if (r_state == S_BUSY_D) begin
                            bus.d_ready <= 1'b1;
                            bus.d_rdata <= bus.mem_we ? '0 : bus.mem_rdata;
                        end else begin
                            bus.i_ready <= 1'b1;
                            bus.i_rdata <= bus.mem_rdata;
                        end
                        r_state <= S_RESP;
                    end else if (r_cnt == C_CNT_LAST) begin
                        bus.mem_en <= 1'b0;
                        bus.mem_we <= 1'b0;
                        bus.err    <= 1'b1;
                        if (r_state == S_BUSY_D) begin
                            bus.d_ready <= 1'b1;
                            bus.d_rdata <= '0;
                        end else begin
                            bus.i_ready <= 1'b1;
                            bus.i_rdata <= '0;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + C_CW'(1);
                    end
                end
                S_RESP: begin
                    // Requester updates its request here; arbitrate next cycle
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
